// File: rtl/alu_pkg.sv
// Shared ALU/branch encodings for the execute stage and the fetch-side branch checker.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned BR_CC_W  = 3;
  localparam int unsigned FLAG_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_PADDSB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 3'd7;

  localparam logic [BR_CC_W-1:0] BR_NE     = 3'd0;
  localparam logic [BR_CC_W-1:0] BR_EQ     = 3'd1;
  localparam logic [BR_CC_W-1:0] BR_GT     = 3'd2;
  localparam logic [BR_CC_W-1:0] BR_LT     = 3'd3;
  localparam logic [BR_CC_W-1:0] BR_GE     = 3'd4;
  localparam logic [BR_CC_W-1:0] BR_LE     = 3'd5;
  localparam logic [BR_CC_W-1:0] BR_OV     = 3'd6;
  localparam logic [BR_CC_W-1:0] BR_UNCOND = 3'd7;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator: condition code + Z/V/N -> taken.
module br_cond_eval
  import alu_pkg::*;
(
  input  logic [BR_CC_W-1:0] i_cond,
  input  logic               i_ze,
  input  logic               i_ve,
  input  logic               i_ne,
  output logic               o_taken_c
);

  always_comb begin
    o_taken_c = 1'b0;
    case (i_cond)
      BR_NE:     o_taken_c = ~i_ze;
      BR_EQ:     o_taken_c = i_ze;
      BR_GT:     o_taken_c = ~i_ze & ~i_ne;
      BR_LT:     o_taken_c = i_ne;
      BR_GE:     o_taken_c = i_ze | ~i_ne;
      BR_LE:     o_taken_c = i_ne | i_ze;
      BR_OV:     o_taken_c = i_ve;
      BR_UNCOND: o_taken_c = 1'b1;
      default:   o_taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: EX/MEM pipeline register, Z/V/N flag register and
// registered branch decision with same-cycle flag bypass.
module ex_flag_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [2:0]          alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zr,
  input  logic                alu_ov,
  input  logic                alu_neg,
  input  logic [RADDR_W-1:0]  in_dst,
  input  logic                in_wr_en,
  input  logic                br_check,
  input  logic [2:0]          br_cond,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_result,
  output logic [RADDR_W-1:0]  out_dst,
  output logic                out_wr_en,
  output logic                flag_z,
  output logic                flag_v,
  output logic                flag_n,
  output logic                br_taken
);

  logic                r_valid;
  logic [DATA_W-1:0]   r_result;
  logic [RADDR_W-1:0]  r_dst;
  logic                r_wr_en;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_br_taken;

  logic                w_accept;
  logic [FLAG_W-1:0]   w_flags_eff;
  logic                w_taken;

  assign w_accept = in_valid & ~stall & ~flush;

  // Flags about to be written; equals r_flags when nothing is accepted, so X on alu_op is masked.
  always_comb begin
    w_flags_eff = r_flags;
    if (w_accept) begin
      case (alu_op)
        ALU_ADD, ALU_SUB: begin
          w_flags_eff[FLAG_Z] = alu_zr;
          w_flags_eff[FLAG_V] = alu_ov;
          w_flags_eff[FLAG_N] = alu_neg;
        end
        ALU_PADDSB: w_flags_eff = r_flags;
        default:    w_flags_eff[FLAG_Z] = alu_zr;
      endcase
    end
  end

  br_cond_eval u_br_cond_eval (
    .i_cond    (br_cond),
    .i_ze      (w_flags_eff[FLAG_Z]),
    .i_ve      (w_flags_eff[FLAG_V]),
    .i_ne      (w_flags_eff[FLAG_N]),
    .o_taken_c (w_taken)
  );

  // EX/MEM pipeline register: flush clears, stall holds, idle drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        r_valid  <= 1'b1;
        r_result <= alu_result;
        r_dst    <= in_dst;
        r_wr_en  <= in_wr_en;
      end else begin
        r_valid  <= 1'b0;
        r_wr_en  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags    <= '0;
      r_br_taken <= 1'b0;
    end else begin
      r_flags    <= w_flags_eff;
      r_br_taken <= br_check & ~flush & ~stall & w_taken;
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_dst    = r_dst;
  assign out_wr_en  = r_wr_en;
  assign flag_z     = r_flags[FLAG_Z];
  assign flag_v     = r_flags[FLAG_V];
  assign flag_n     = r_flags[FLAG_N];
  assign br_taken   = r_br_taken;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage with a queue-based scoreboard of expected outputs.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zr, alu_ov, alu_neg;
  logic [3:0]  in_dst;
  logic        in_wr_en;
  logic        br_check;
  logic [2:0]  br_cond;
  logic        stall, flush;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_wr_en;
  logic        flag_z, flag_v, flag_n;
  logic        br_taken;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [15:0] result;
    logic [3:0]  dst;
    logic        wr;
    logic        z, v, n, br;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  ex_flag_stage #(.DATA_W(16), .RADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zr(alu_zr), .alu_ov(alu_ov), .alu_neg(alu_neg),
    .in_dst(in_dst), .in_wr_en(in_wr_en), .br_check(br_check), .br_cond(br_cond),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_result(out_result),
    .out_dst(out_dst), .out_wr_en(out_wr_en), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [2:0] c, input logic z, input logic v, input logic n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m = '{valid: 1'b0, result: 16'h0, dst: 4'h0, wr: 1'b0, z: 1'b0, v: 1'b0, n: 1'b0, br: 1'b0};
  endtask

  // Advance the model by one edge using the currently driven inputs and push the expectation.
  task automatic model_step();
    logic acc, ze, ve, ne;
    acc = in_valid && !stall && !flush;
    ze = m.z; ve = m.v; ne = m.n;
    if (acc) begin
      if (alu_op == 3'd0 || alu_op == 3'd2) begin
        ze = alu_zr; ve = alu_ov; ne = alu_neg;
      end else if (alu_op != 3'd1) begin
        ze = alu_zr;
      end
    end
    m.br = br_check && !flush && !stall && cond_ref(br_cond, ze, ve, ne);
    m.z = ze; m.v = ve; m.n = ne;
    if (flush) begin
      m.valid = 1'b0; m.wr = 1'b0; m.result = 16'h0; m.dst = 4'h0;
    end else if (!stall) begin
      if (in_valid) begin
        m.valid = 1'b1; m.result = alu_result; m.dst = in_dst; m.wr = in_wr_en;
      end else begin
        m.valid = 1'b0; m.wr = 1'b0;
      end
    end
    sb.push_back(m);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
    chk({tag, ".wr_en"}, 32'(out_wr_en), 32'(e.wr));
    if (e.valid) begin
      chk({tag, ".result"}, 32'(out_result), 32'(e.result));
      chk({tag, ".dst"}, 32'(out_dst), 32'(e.dst));
    end
    chk({tag, ".z"}, 32'(flag_z), 32'(e.z));
    chk({tag, ".v"}, 32'(flag_v), 32'(e.v));
    chk({tag, ".n"}, 32'(flag_n), 32'(e.n));
    chk({tag, ".br"}, 32'(br_taken), 32'(e.br));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic idle();
    in_valid = 1'b0; alu_op = 3'd0; alu_result = 16'h0; alu_zr = 1'b0; alu_ov = 1'b0;
    alu_neg = 1'b0; in_dst = 4'h0; in_wr_en = 1'b0; br_check = 1'b0; br_cond = 3'd0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic op(input logic [2:0] o, input logic [15:0] r, input logic zr,
                    input logic ov, input logic ng, input logic [3:0] d, input logic w);
    idle();
    in_valid = 1'b1; alu_op = o; alu_result = r; alu_zr = zr; alu_ov = ov;
    alu_neg = ng; in_dst = d; in_wr_en = w;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".result"}, 32'(out_result), 32'd0);
    chk({tag, ".dst"}, 32'(out_dst), 32'd0);
    chk({tag, ".wr_en"}, 32'(out_wr_en), 32'd0);
    chk({tag, ".flags"}, 32'({flag_z, flag_v, flag_n}), 32'd0);
    chk({tag, ".br"}, 32'(br_taken), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #12;
    chk_all_zero("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-operation
    op(3'd0, 16'h1234, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1);
    step("rst_pre");
    op(3'd0, 16'h5678, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    #2;
    rst = 1'b0;
    op(3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1);
    step("rst_sub");

    // Selective flag update
    op(3'd0, 16'h8001, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1);
    step("sel_add");
    op(3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1);
    step("sel_and");
    op(3'd1, 16'h0101, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1);
    step("sel_paddsb");
    op(3'd7, 16'hF000, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0);
    step("sel_sra");

    // Same-cycle bypass into the branch evaluator
    op(3'd0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1);
    step("byp_setup");
    op(3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1);
    br_check = 1'b1; br_cond = 3'd1;
    step("byp_eq");
    op(3'd0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1);
    step("byp_setup2");
    op(3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1);
    br_check = 1'b1; br_cond = 3'd1; stall = 1'b1;
    step("byp_stall");
    idle();
    step("br_pulse_end");

    // Flush dominates stall; stall holds outputs
    op(3'd0, 16'hABCD, 1'b0, 1'b0, 1'b1, 4'h9, 1'b1);
    step("fs_load");
    op(3'd0, 16'h00FF, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1);
    stall = 1'b1; flush = 1'b1;
    step("fs_flush");
    op(3'd4, 16'h4321, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1);
    step("fs_reload");
    for (int i = 0; i < 3; i++) begin
      op(3'd0, 16'(16'h1111 * (i + 1)), 1'b1, 1'b1, 1'b1, 4'hF, 1'b0);
      stall = 1'b1;
      step("fs_stall");
    end

    // X on opcode with no valid instruction
    idle();
    alu_op = 3'bxxx; alu_zr = 1'b1; alu_ov = 1'b1; alu_neg = 1'b1;
    step("x_op");

    // Condition sweep over all flag combinations and codes
    for (int f = 0; f < 8; f++) begin
      op(3'd0, 16'h0, f[2], f[1], f[0], 4'h0, 1'b0);
      step("sweep_set");
      for (int c = 0; c < 8; c++) begin
        idle();
        br_check = 1'b1; br_cond = 3'(c);
        step("sweep_cond");
      end
    end

    // Back-to-back throughput
    for (int i = 0; i < 10; i++) begin
      op(3'(i % 8), 16'($urandom), 1'(i % 3 == 0), 1'(i % 2), 1'(i % 5 == 1), 4'(i), 1'(i % 2));
      step("b2b");
    end
    idle();
    step("b2b_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Execute-stage back end that sits directly downstream of the 16-bit ALU.
- Captures the ALU result into the EX/MEM pipeline register and maintains the architectural Z/V/N flag register with per-opcode update rules.
- Evaluates branch conditions against the flags, with same-cycle bypass. Supports pipeline stall and flush.

Parameters:
DATA_W, 16, ALU result / datapath width
RADDR_W, 4, destination register index width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU stage holds a valid instruction this cycle
alu_op  input  3  ALU opcode: 0 ADD, 1 PADDSB, 2 SUB, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SRA
alu_result  input  DATA_W  ALU result
alu_zr  input  1  ALU zero flag
alu_ov  input  1  ALU overflow flag
alu_neg  input  1  ALU negative flag
in_dst  input  RADDR_W  destination register index
in_wr_en  input  1  instruction writes a register
br_check  input  1  branch instruction present; evaluate condition
br_cond  input  3  condition code (see Behaviour)
stall  input  1  hold pipeline register and flags
flush  input  1  squash the incoming instruction
out_valid  output  1  EX/MEM register holds a valid instruction
out_result  output  DATA_W  registered ALU result
out_dst  output  RADDR_W  registered destination index
out_wr_en  output  1  registered write enable (forced 0 when out_valid=0)
flag_z, flag_v, flag_n  output  1 each  architectural flag register
br_taken  output  1  registered branch decision, valid one cycle after br_check

Behaviour:
- Reset (async, rst=1): out_valid, out_result, out_dst, out_wr_en, flag_z/v/n and br_taken all 0 immediately; they stay 0 while rst is held.
- Accept condition: accept = in_valid & ~stall & ~flush.
- Pipeline register, latency 1:
  - On accept, capture result/dst/wr_en and set out_valid=1.
  - On flush, out_valid=0 and out_wr_en=0 next cycle; result/dst are don't-care but cleared to 0.
  - On stall with no flush, all outputs hold.
  - On ~in_valid with no stall/flush, out_valid=0.
- Flag update (only on accept):
  - ADD, SUB: Z<=alu_zr, V<=alu_ov, N<=alu_neg.
  - AND, NOR, SLL, SRL, SRA: Z<=alu_zr; V and N hold.
  - PADDSB: no flag change.
- Flush priority: flush dominates stall, and no flag update occurs on a flushed op.
- Branch conditions, evaluated on effective flags (Ze/Ve/Ne):
  - 000 NE: ~Ze
  - 001 EQ: Ze
  - 010 GT: ~Ze & ~Ne
  - 011 LT: Ne
  - 100 GE: Ze | ~Ne
  - 101 LE: Ne | Ze
  - 110 OV: Ve
  - 111 UNCOND: 1
- Effective-flag bypass: if an accepted flag-setting op arrives in the same cycle as br_check, the effective flags are the values about to be written (per-flag, per the update rules above). Otherwise they are the registered flags.
- br_taken register:
  - Next cycle, br_taken <= br_check & ~flush & ~stall & cond.
  - It is a single-cycle pulse; it returns to 0 the following cycle unless re-asserted.
  - A stalled br_check produces br_taken=0 and must be re-presented.
- Unknown/X on alu_op while in_valid=0 has no effect on any state.

Decomposition:
- Shared package (alu_pkg) holds:
  - ALU opcode constants ALU_ADD..ALU_SRA (3-bit).
  - Branch condition constants BR_NE..BR_UNCOND.
  - Flag index constants FLAG_Z/V/N.
- One sub-module: br_cond_eval (combinational: cond + Ze/Ve/Ne -> taken). Reused by the fetch-side branch predictor checker.
- Flag-update mask logic stays inline.

Test Plan:
- Reset mid-operation: drive ADD result 0x1234 with flags set, assert rst between edges -> all outputs 0 immediately; after release, the first accepted SUB 0x0000 with zr=1 gives out_result=0x0000 and flag_z=1 one cycle later.
- Selective update: ADD with zr=0, ov=1, neg=1 -> Z=0, V=1, N=1. Then AND with zr=1 -> Z=1, V=1, N=1. Then PADDSB with zr=0 -> flags unchanged.
- Bypass: flags Z=0, N=0; same cycle, accepted SUB with zr=1 and br_check with cond=EQ -> br_taken=1 next cycle. Repeat with stall=1 -> br_taken=0 and flags unchanged.
- Flush vs stall: flush=1 and stall=1 with valid ADD 0x00FF -> next cycle out_valid=0, out_wr_en=0, flags unchanged. Stall alone for 3 cycles -> out_result holds its prior value.
- Condition sweep: for each of the 8 Z/V/N combinations, check all 8 br_cond codes against the truth table -> br_taken matches, including GT=0 when Z=1, N=0, and UNCOND=1 always.
- Back-to-back throughput: 10 consecutive valid ops with no stall -> out_valid stays high, each out_result appears exactly 1 cycle after input, and out_dst/out_wr_en are aligned with it.
